cmd_bus_router: RTL and testbench
=================================

Name: cmd_bus_router

Overview:
- Parametrised store-and-forward command packet router, successor to the fixed 3-way command splitter between the UART DMA receive path and the ADC/flash/control consumers.
- The first byte of each packet is a destination ID. The router buffers the whole packet in a ping-pong bank pair and validates its length. It then forwards the payload, header stripped, to one of P_CH_NUM output channels with per-channel ready back-pressure.
- Invalid packets are dropped and counted.

Parameters:
- P_CH_NUM, 3, number of output channels (1..8)
- P_ID_BASE, 8'h01, header ID mapped to channel 0; channel k = ID - P_ID_BASE
- P_BUF_DEPTH, 64, bytes per bank (power of 2, ≥ max payload)
- P_DW, 8, data width

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset
- i_cmd_data  in  P_DW  incoming packet byte
- i_cmd_len  in  8  total packet length incl. header, stable across the packet
- i_cmd_last  in  1  final byte of packet
- i_cmd_valid  in  1  byte strobe (no upstream ready exists)
- o_ch_data  out  P_CH_NUM*P_DW  flattened payload byte, channel k at [k*P_DW +: P_DW]
- o_ch_len  out  P_CH_NUM*8  payload length (= i_cmd_len - 1)
- o_ch_last  out  P_CH_NUM  last payload byte
- o_ch_valid  out  P_CH_NUM  byte valid
- i_ch_ready  in  P_CH_NUM  consumer ready
- o_drop_cnt  out  16  saturating dropped-packet count
- o_drop_pulse  out  1  one-cycle strobe per drop

Interface rule: one clock (i_clk); reset i_rst is synchronous and active-high.

Behaviour:
- Reset values: all o_ch_* = 0, o_drop_cnt = 0, o_drop_pulse = 0, both banks EMPTY, write pointer at bank 0, RX in RX_HDR.
- Receive FSM:
  - RX_HDR: on valid, latch ID and len, reset byte count to 1. If i_cmd_last is also set: drop (length < 2).
  - Otherwise go to RX_PAY if the target bank is EMPTY, else RX_DROP.
  - RX_PAY: write each valid byte to the bank and increment the count.
  - On last in RX_PAY: the packet is good if count+1 == len, len ≥ 2, len-1 ≤ P_BUF_DEPTH, and ID is in [P_ID_BASE, P_ID_BASE+P_CH_NUM-1]. A good packet marks the bank FULL with its descriptor (channel, payload len) and toggles the write bank. A bad packet leaves the bank EMPTY and drops.
  - Writing past P_BUF_DEPTH moves to RX_DROP.
  - RX_DROP: discard bytes until last, then drop and return to RX_HDR.
  - Every RX state returns to RX_HDR after a last byte.
- Drop: o_drop_pulse high exactly one cycle after the offending last byte. o_drop_cnt increments and saturates at 16'hFFFF.
- Transmit FSM (TX_IDLE, TX_RD, TX_SEND):
  - TX_IDLE: if the read bank is FULL, go to TX_RD, which performs a registered memory read.
  - First o_ch_valid[k] rises 2 cycles after the commit cycle when TX is idle.
  - In TX_SEND, data/len/last are held stable while valid && !ready. On valid && ready, advance one byte per cycle (prefetched read, no bubbles).
  - After the last handshake: bank becomes EMPTY, read bank toggles, return to TX_IDLE. Back-to-back packets have a 1-cycle gap (TX_RD).
  - Only the addressed channel's valid is ever asserted. All other channels' outputs stay 0.
- Simultaneous commit on bank A and release of bank B in the same cycle are both honoured.
- If both banks are FULL, a new packet goes to RX_DROP; the packet already buffered is unaffected.
- Reset mid-packet: partial packet discarded. Leftover tail bytes are parsed as a new packet and dropped by the length check.

Optional Feature:
- CMD_ROUTER_BROADCAST_EN defined: ID 8'hFF is valid.
  - Payload is presented on all channels simultaneously with identical data/len/last.
  - Advance only when all P_CH_NUM readies are high.
- Undefined: 8'hFF is treated as an out-of-range ID and dropped.

Decomposition:
- Package cmd_router_pkg:
  - rx_state_t and tx_state_t enums
  - BCAST_ID = 8'hFF
  - bank status enum (EMPTY/FULL)
  - descriptor struct {chan, len}
- Sub-module cmd_pkt_bank: one bank's storage (simple dual-port RAM, registered read) plus its FULL flag and descriptor. Instantiated twice.

Test Plan:
- ID 8'h02, len 5, payload 11 22 33 44, all ready high -> ch1 outputs 11,22,33,44 with o_ch_len = 4, last on 44, first valid 2 cycles after input last; ch0/ch2 silent.
- Same packet with i_ch_ready[1] low for 3 cycles mid-payload -> data held stable, no byte lost or duplicated.
- Declared len 6 but only 5 bytes sent -> nothing forwarded, o_drop_pulse one cycle, o_drop_cnt = 1.
- ID 8'h09 (out of range), then 3 back-to-back valid packets with ch0 ready low -> first dropped; second and third fill both banks; fourth-arrival packet dropped, count = 2; after ready rises, packets emerge in order.
- Assert i_rst after 2 payload bytes, then send a fresh valid packet -> tail of old packet dropped, fresh packet forwarded intact.
- With CMD_ROUTER_BROADCAST_EN, ID 8'hFF len 3 payload AA BB, one channel's ready low -> all channels valid, no advance until all ready; without the macro -> dropped.

Source files
------------

// File: rtl/cmd_router_pkg.sv
// cmd_router_pkg
// Shared types for the command packet router: receive/transmit FSM state
// encodings, per-bank status, the descriptor stored with a buffered packet,
// and the broadcast header ID.
// Ports: none (package).
package cmd_router_pkg;

   typedef enum logic [1:0] {
      RX_HDR  = 2'd0,
      RX_PAY  = 2'd1,
      RX_DROP = 2'd2
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_RD   = 2'd1,
      TX_SEND = 2'd2
   } tx_state_t;

   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_stat_t;

   // Header ID that addresses every channel when broadcast is enabled.
   localparam logic [7:0] BCAST_ID = 8'hFF;

   // chan: channel index, or BCAST_ID for a broadcast packet.
   // len : payload length (header excluded).
   typedef struct packed {
      logic [7:0] chan;
      logic [7:0] len;
   } desc_t;

endpackage

// File: rtl/cmd_pkt_bank.sv
// cmd_pkt_bank
// One ping-pong bank: simple dual-port byte store with registered read,
// plus the FULL/EMPTY status and the descriptor of the packet it holds.
// Ports:
//   clk, rst          clock, synchronous active-high reset (status only)
//   wr_en/addr/data   payload write port
//   rd_addr, rd_data  read port, rd_data valid the cycle after rd_addr
//   commit, commit_desc  mark bank FULL and store its descriptor
//   rel               return bank to EMPTY after transmission
//   full, desc        current status and descriptor
module cmd_pkt_bank
   import cmd_router_pkg::*;
#(
   parameter int P_BUF_DEPTH = 64,
   parameter int P_DW        = 8,
   localparam int AW         = (P_BUF_DEPTH > 1) ? $clog2(P_BUF_DEPTH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [P_DW-1:0] wr_data,
   input  logic [AW-1:0]   rd_addr,
   output logic [P_DW-1:0] rd_data,
   input  logic            commit,
   input  desc_t           commit_desc,
   input  logic            rel,
   output logic            full,
   output desc_t           desc
);

   logic [P_DW-1:0] mem [P_BUF_DEPTH];
   bank_stat_t      stat;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         desc <= commit_desc;
      end
   end

   // Commit and release never target the same bank in one cycle: RX only
   // fills an EMPTY bank, TX only drains a FULL one.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat <= BANK_EMPTY;
      end else if (commit) begin
         stat <= BANK_FULL;
      end else if (rel) begin
         stat <= BANK_EMPTY;
      end
   end

   assign full = (stat == BANK_FULL);

endmodule

// File: rtl/cmd_bus_router.sv
// cmd_bus_router
// Store-and-forward command packet router. The first byte of each packet is
// a destination ID; the packet is buffered in one of two banks, validated,
// and its payload (header stripped) is forwarded to one output channel with
// per-channel ready back-pressure. Invalid packets are dropped and counted.
// Optional feature: define CMD_ROUTER_BROADCAST_EN to accept ID 8'hFF as a
// broadcast to all channels (advances only when every channel is ready).
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_cmd_data/len/last/valid  incoming packet byte stream (no ready)
//   o_ch_data/len/last/valid   per-channel flattened payload outputs
//   i_ch_ready         per-channel consumer ready
//   o_drop_cnt         saturating dropped-packet counter
//   o_drop_pulse       one-cycle strobe per dropped packet
module cmd_bus_router
   import cmd_router_pkg::*;
#(
   parameter int         P_CH_NUM    = 3,
   parameter logic [7:0] P_ID_BASE   = 8'h01,
   parameter int         P_BUF_DEPTH = 64,
   parameter int         P_DW        = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [P_DW-1:0]          i_cmd_data,
   input  logic [7:0]               i_cmd_len,
   input  logic                     i_cmd_last,
   input  logic                     i_cmd_valid,
   output logic [P_CH_NUM*P_DW-1:0] o_ch_data,
   output logic [P_CH_NUM*8-1:0]    o_ch_len,
   output logic [P_CH_NUM-1:0]      o_ch_last,
   output logic [P_CH_NUM-1:0]      o_ch_valid,
   input  logic [P_CH_NUM-1:0]      i_ch_ready,
   output logic [15:0]              o_drop_cnt,
   output logic                     o_drop_pulse
);

   localparam int AW = (P_BUF_DEPTH > 1) ? $clog2(P_BUF_DEPTH) : 1;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Receive side
   rx_state_t  rx_state;
   logic       wr_bank;
   logic [7:0] hdr_id;
   logic [7:0] hdr_len;
   logic [9:0] cnt;        // bytes received so far, header included
   logic [9:0] pay_idx;
   logic       in_range;
   logic [8:0] id_off;
   logic       id_ok;
   logic       rx_bcast;
   logic       pkt_good;
   logic       wr_en;
   logic       commit_evt;
   logic       drop_evt;
   desc_t      new_desc;

   // Transmit side
   tx_state_t       tx_state;
   logic            rd_bank;
   logic [AW-1:0]   ptr;
   logic [AW-1:0]   rd_addr;
   desc_t           cur_desc;
   logic [P_DW-1:0] cur_data;
   logic            tx_bcast;
   logic            ready_sel;
   logic            tx_fire;
   logic            tx_last;
   logic            rel_evt;
   logic            avail_now;
   logic            avail_next;

   // Bank array
   logic [1:0]      bank_full;
   desc_t           bank_desc [2];
   logic [P_DW-1:0] bank_rd_data [2];

   always_comb begin
      id_off = {1'b0, hdr_id} - {1'b0, P_ID_BASE};
      id_ok  = (hdr_id >= P_ID_BASE) && (id_off < 9'(P_CH_NUM));
`ifdef CMD_ROUTER_BROADCAST_EN
      rx_bcast = (hdr_id == BCAST_ID);
`else
      rx_bcast = 1'b0;
`endif
      new_desc.chan = rx_bcast ? BCAST_ID : id_off[7:0];
      new_desc.len  = hdr_len - 8'd1;
   end

   always_comb begin
      pay_idx    = cnt - 10'd1;
      in_range   = (pay_idx < 10'(P_BUF_DEPTH));
      // Evaluated on the last byte, which brings the total to cnt+1.
      pkt_good   = ({2'b00, hdr_len} == cnt + 10'd1) && (hdr_len >= 8'd2) &&
                   ({2'b00, hdr_len} <= 10'(P_BUF_DEPTH + 1)) && (id_ok || rx_bcast);
      wr_en      = 1'b0;
      commit_evt = 1'b0;
      drop_evt   = 1'b0;
      case (rx_state)
         RX_HDR: begin
            if (i_cmd_valid && i_cmd_last) drop_evt = 1'b1;
         end
         RX_PAY: begin
            if (i_cmd_valid) begin
               if (in_range) begin
                  wr_en = 1'b1;
                  if (i_cmd_last) begin
                     commit_evt = pkt_good;
                     drop_evt   = !pkt_good;
                  end
               end else if (i_cmd_last) begin
                  drop_evt = 1'b1;
               end
            end
         end
         RX_DROP: begin
            if (i_cmd_valid && i_cmd_last) drop_evt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_state <= RX_HDR;
         wr_bank  <= 1'b0;
      end else begin
         case (rx_state)
            RX_HDR: begin
               if (i_cmd_valid && !i_cmd_last) begin
                  rx_state <= bank_full[wr_bank] ? RX_DROP : RX_PAY;
               end
            end
            RX_PAY: begin
               if (i_cmd_valid) begin
                  if (i_cmd_last) begin
                     rx_state <= RX_HDR;
                     if (commit_evt) wr_bank <= ~wr_bank;
                  end else if (!in_range) begin
                     rx_state <= RX_DROP;
                  end
               end
            end
            RX_DROP: begin
               if (i_cmd_valid && i_cmd_last) rx_state <= RX_HDR;
            end
            default: rx_state <= RX_HDR;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (rx_state == RX_HDR && i_cmd_valid) begin
         hdr_id  <= i_cmd_data[7:0];
         hdr_len <= i_cmd_len;
         cnt     <= 10'd1;
      end else if (rx_state == RX_PAY && i_cmd_valid && in_range) begin
         cnt <= cnt + 10'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_drop_pulse <= 1'b0;
         o_drop_cnt   <= 16'd0;
      end else begin
         o_drop_pulse <= drop_evt;
         if (drop_evt) o_drop_cnt <= sat_inc(o_drop_cnt);
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      cmd_pkt_bank #(
         .P_BUF_DEPTH(P_BUF_DEPTH),
         .P_DW       (P_DW)
      ) u_bank (
         .clk        (i_clk),
         .rst        (i_rst),
         .wr_en      (wr_en && (wr_bank == 1'(b))),
         .wr_addr    (pay_idx[AW-1:0]),
         .wr_data    (i_cmd_data),
         .rd_addr    (rd_addr),
         .rd_data    (bank_rd_data[b]),
         .commit     (commit_evt && (wr_bank == 1'(b))),
         .commit_desc(new_desc),
         .rel        (rel_evt && (rd_bank == 1'(b))),
         .full       (bank_full[b]),
         .desc       (bank_desc[b])
      );
   end

   always_comb begin
      cur_desc = bank_desc[rd_bank];
      cur_data = bank_rd_data[rd_bank];
`ifdef CMD_ROUTER_BROADCAST_EN
      tx_bcast = (cur_desc.chan == BCAST_ID);
`else
      tx_bcast = 1'b0;
`endif
      ready_sel = 1'b0;
      for (int k = 0; k < P_CH_NUM; k++) begin
         if (cur_desc.chan == 8'(k)) ready_sel = i_ch_ready[k];
      end
      if (tx_bcast) ready_sel = &i_ch_ready;
      tx_fire = (tx_state == TX_SEND) && ready_sel;
      tx_last = (8'(ptr) == cur_desc.len - 8'd1);
      rel_evt = tx_fire && tx_last;
      // A commit in this very cycle counts as FULL so TX starts one cycle
      // earlier than waiting for the registered status.
      avail_now  = bank_full[rd_bank] || (commit_evt && (wr_bank == rd_bank));
      avail_next = bank_full[~rd_bank] || (commit_evt && (wr_bank != rd_bank));
      // Registered read runs every cycle: re-reading ptr holds the byte
      // under back-pressure, reading ptr+1 on a handshake prefetches the next.
      if (tx_state == TX_SEND) begin
         rd_addr = tx_fire ? ptr + AW'(1) : ptr;
      end else begin
         rd_addr = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_state <= TX_IDLE;
         rd_bank  <= 1'b0;
      end else begin
         case (tx_state)
            TX_IDLE: if (avail_now) tx_state <= TX_RD;
            TX_RD:   tx_state <= TX_SEND;
            TX_SEND: begin
               if (rel_evt) begin
                  rd_bank  <= ~rd_bank;
                  tx_state <= avail_next ? TX_RD : TX_IDLE;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (tx_state == TX_RD) begin
         ptr <= '0;
      end else if (tx_fire) begin
         ptr <= ptr + AW'(1);
      end
   end

   always_comb begin
      o_ch_data  = '0;
      o_ch_len   = '0;
      o_ch_last  = '0;
      o_ch_valid = '0;
      for (int k = 0; k < P_CH_NUM; k++) begin
         if ((tx_state == TX_SEND) && ((cur_desc.chan == 8'(k)) || tx_bcast)) begin
            o_ch_valid[k]              = 1'b1;
            o_ch_data[k*P_DW +: P_DW]  = cur_data;
            o_ch_len[k*8 +: 8]         = cur_desc.len;
            o_ch_last[k]               = tx_last;
         end
      end
   end

endmodule

// File: tb/tb_cmd_bus_router.sv
// tb_cmd_bus_router
// Scoreboard bench for cmd_bus_router: stimulus pushes expected payload
// beats and drop counts into queues; a negedge monitor compares whatever
// the router presents against the queue heads.
module tb_cmd_bus_router;
   localparam int NCH = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        i_cmd_data;
   logic [7:0]        i_cmd_len;
   logic              i_cmd_last;
   logic              i_cmd_valid;
   logic [NCH*8-1:0]  o_ch_data;
   logic [NCH*8-1:0]  o_ch_len;
   logic [NCH-1:0]    o_ch_last;
   logic [NCH-1:0]    o_ch_valid;
   logic [NCH-1:0]    i_ch_ready;
   logic [15:0]       o_drop_cnt;
   logic              o_drop_pulse;

   always #5 clk = ~clk;

   cmd_bus_router #(
      .P_CH_NUM   (NCH),
      .P_ID_BASE  (8'h01),
      .P_BUF_DEPTH(64),
      .P_DW       (8)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_cmd_data  (i_cmd_data),
      .i_cmd_len   (i_cmd_len),
      .i_cmd_last  (i_cmd_last),
      .i_cmd_valid (i_cmd_valid),
      .o_ch_data   (o_ch_data),
      .o_ch_len    (o_ch_len),
      .o_ch_last   (o_ch_last),
      .o_ch_valid  (o_ch_valid),
      .i_ch_ready  (i_ch_ready),
      .o_drop_cnt  (o_drop_cnt),
      .o_drop_pulse(o_drop_pulse)
   );

   typedef struct packed {
      logic [NCH-1:0] mask;
      logic [7:0]     data;
      logic [7:0]     len;
      logic           last;
   } beat_t;

   beat_t       exp_q[$];
   logic [15:0] drop_q[$];
   int          checks = 0;
   int          errors = 0;
   int          exp_drop = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_pkt(input logic [NCH-1:0] mask, input int n, input logic [63:0] p);
      beat_t e;
      for (int i = 0; i < n; i++) begin
         e.mask = mask;
         e.data = p[i*8 +: 8];
         e.len  = 8'(n);
         e.last = (i == n - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic push_drop();
      exp_drop++;
      drop_q.push_back(16'(exp_drop));
   endtask

   task automatic send_byte(input logic [7:0] d, input logic [7:0] len, input logic last);
      i_cmd_data  = d;
      i_cmd_len   = len;
      i_cmd_last  = last;
      i_cmd_valid = 1'b1;
      @(posedge clk); #1;
      i_cmd_valid = 1'b0;
      i_cmd_last  = 1'b0;
   endtask

   // b[7:0] is the header byte, following bytes in ascending order.
   task automatic send_pkt(input logic [7:0] len, input int n, input logic [63:0] b);
      for (int i = 0; i < n; i++) begin
         send_byte(b[i*8 +: 8], len, (i == n - 1));
      end
   endtask

   task automatic drain(input string name, input int max);
      int n = 0;
      while ((exp_q.size() != 0 || drop_q.size() != 0) && n < max) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, 64'(exp_q.size() + drop_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_drop = 0;
      drop_q.delete();
   endtask

   // Monitor: compares the full output vectors against the queue head while
   // valid (including stalled cycles), pops on a completed handshake.
   always @(negedge clk) begin : mon
      beat_t            e;
      logic [NCH*8-1:0] dv;
      logic [NCH*8-1:0] lv;
      logic [NCH-1:0]   tv;
      if (!rst) begin
         if (o_ch_valid != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 64'(o_ch_valid), 64'd0);
            end else begin
               e  = exp_q[0];
               dv = '0;
               lv = '0;
               tv = '0;
               for (int k = 0; k < NCH; k++) begin
                  if (e.mask[k]) begin
                     dv[k*8 +: 8] = e.data;
                     lv[k*8 +: 8] = e.len;
                     tv[k]        = e.last;
                  end
               end
               chk("ch_valid", 64'(o_ch_valid), 64'(e.mask));
               chk("ch_data", 64'(o_ch_data), 64'(dv));
               chk("ch_len", 64'(o_ch_len), 64'(lv));
               chk("ch_last", 64'(o_ch_last), 64'(tv));
               if ((o_ch_valid & i_ch_ready) == o_ch_valid) void'(exp_q.pop_front());
            end
         end else begin
            chk("idle_outputs", 64'({o_ch_data, o_ch_len, o_ch_last}), 64'd0);
         end
         if (o_drop_pulse) begin
            if (drop_q.size() == 0) begin
               chk("unexpected_drop", 64'(o_drop_pulse), 64'd0);
            end else begin
               chk("drop_cnt", 64'(o_drop_cnt), 64'(drop_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      rst         = 1'b1;
      i_cmd_data  = '0;
      i_cmd_len   = '0;
      i_cmd_last  = 1'b0;
      i_cmd_valid = 1'b0;
      i_ch_ready  = 3'b111;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_valid", 64'(o_ch_valid), 64'd0);
      chk("rst_data", 64'(o_ch_data), 64'd0);
      chk("rst_len", 64'(o_ch_len), 64'd0);
      chk("rst_last", 64'(o_ch_last), 64'd0);
      chk("rst_drop_cnt", 64'(o_drop_cnt), 64'd0);
      chk("rst_drop_pulse", 64'(o_drop_pulse), 64'd0);
      @(posedge clk); #1;

      // T1: ID 02 len 5 -> ch1 gets 11 22 33 44, len 4; first valid two
      // cycles after the last input byte.
      push_pkt(3'b010, 4, 64'h44332211);
      send_pkt(8'd5, 5, 64'h44332211_02);
      @(negedge clk);
      chk("t1_valid_cycle1", 64'(o_ch_valid), 64'd0);
      @(negedge clk);
      chk("t1_valid_cycle2", 64'(o_ch_valid), 64'b010);
      drain("t1_drain", 50);

      // T2: same packet, ch1 ready low for 3 cycles mid-payload.
      push_pkt(3'b010, 4, 64'h44332211);
      send_pkt(8'd5, 5, 64'h44332211_02);
      repeat (3) @(posedge clk);
      #1;
      i_ch_ready[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      i_ch_ready[1] = 1'b1;
      drain("t2_drain", 50);

      // T3: declared len 6, only 5 bytes -> dropped, one-cycle pulse.
      push_drop();
      send_pkt(8'd6, 5, 64'h44332211_02);
      @(negedge clk);
      chk("t3_pulse_hi", 64'(o_drop_pulse), 64'd1);
      chk("t3_cnt", 64'(o_drop_cnt), 64'd1);
      @(negedge clk);
      chk("t3_pulse_lo", 64'(o_drop_pulse), 64'd0);
      // Header-only packet (last on first byte) is too short.
      push_drop();
      send_byte(8'h02, 8'd1, 1'b1);
      drain("t3_drain", 50);

      // T4: out-of-range ID dropped; with ch0 stalled, two packets fill both
      // banks and the third is dropped; then both emerge in order.
      do_reset();
      i_ch_ready[0] = 1'b0;
      push_drop();
      push_pkt(3'b001, 2, 64'hA2A1);
      push_pkt(3'b001, 2, 64'hB2B1);
      push_drop();
      send_pkt(8'd3, 3, 64'hD2D1_09);
      send_pkt(8'd3, 3, 64'hA2A1_01);
      send_pkt(8'd3, 3, 64'hB2B1_01);
      send_pkt(8'd3, 3, 64'hC2C1_01);
      repeat (4) @(negedge clk);
      chk("t4_drop_cnt", 64'(o_drop_cnt), 64'd2);
      chk("t4_stalled_valid", 64'(o_ch_valid), 64'b001);
      @(posedge clk); #1;
      i_ch_ready[0] = 1'b1;
      drain("t4_drain", 50);

      // T5: reset after two payload bytes; tail is reparsed and dropped,
      // fresh packet is forwarded intact.
      send_byte(8'h02, 8'd5, 1'b0);
      send_byte(8'h11, 8'd5, 1'b0);
      send_byte(8'h22, 8'd5, 1'b0);
      do_reset();
      @(negedge clk);
      chk("t5_rst_drop_cnt", 64'(o_drop_cnt), 64'd0);
      @(posedge clk); #1;
      push_drop();
      send_byte(8'h33, 8'd5, 1'b0);
      send_byte(8'h44, 8'd5, 1'b1);
      push_pkt(3'b010, 4, 64'h88776655);
      send_pkt(8'd5, 5, 64'h88776655_02);
      drain("t5_drain", 50);

      // T6: broadcast ID 8'hFF, len 3, payload AA BB.
`ifdef CMD_ROUTER_BROADCAST_EN
      i_ch_ready[2] = 1'b0;
      push_pkt(3'b111, 2, 64'hBBAA);
      send_pkt(8'd3, 3, 64'hBBAA_FF);
      repeat (5) @(negedge clk);
      chk("t6_bcast_valid", 64'(o_ch_valid), 64'b111);
      chk("t6_bcast_hold", 64'(o_ch_data), 64'hAAAAAA);
      @(posedge clk); #1;
      i_ch_ready[2] = 1'b1;
`else
      push_drop();
      send_pkt(8'd3, 3, 64'hBBAA_FF);
      repeat (3) @(negedge clk);
      chk("t6_bcast_dropped", 64'(o_drop_cnt), 64'd2);
      @(posedge clk); #1;
`endif
      drain("t6_drain", 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
